shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Serial-in, parallel-out word assembler.
- Receives the bit stream produced by the team's parallel-load/shift-right register, one bit per qualified cycle.
- Rebuilds WIDTH-bit words and presents them on a valid/ready output port through a one-entry holding register.
- Sits at the receive end of the serial link and feeds downstream parallel logic.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = the first received bit is word bit 0 (matches the shift-right transmitter); 0 = the first received bit is word bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sin_valid  input  1  sin_data is a valid bit this cycle.
- sin_data  input  1  serial data bit.
- frame_start  input  1  discard any partial word; realign to a word boundary.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream accepts dout this cycle.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits collected in the current partial word.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- overrun_sticky  output  1  latched overrun, cleared by clr_err.
- clr_err  input  1  clears overrun_sticky.

Behaviour:
- Reset (rst_n low, async): shreg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, overrun_sticky=0, state=COLLECT.
- Shift, LSB_FIRST=1: shreg <= {sin_data, shreg[WIDTH-1:1]}.
- Shift, LSB_FIRST=0: shreg <= {shreg[WIDTH-2:0], sin_data}.
- Shift occurs only on sin_valid=1. sin_valid=0 leaves shreg and bit_cnt unchanged; gaps of any length are legal.
- bit_cnt increments per accepted bit. On the WIDTH-th bit it returns to 0 and the word is complete; the word is the shifted shreg value including that bit.
- Latency: dout/dout_valid update in the cycle after the last bit is sampled (1 clk).
- Output handshake:
  - Transfer occurs when dout_valid && dout_ready.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - dout_valid is held until transfer.
- Word completes while the holding register is empty, or transfers in the same cycle: load dout, dout_valid=1. Back-to-back words at full rate produce no loss if dout_ready=1.
- Word completes while dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overrun=1 for exactly one cycle, overrun_sticky=1.
- frame_start=1, sin_valid=0: shreg=0, bit_cnt=0.
- frame_start=1, sin_valid=1: partial word discarded; the current bit becomes bit 1 of the new word (bit_cnt=1, shreg holds only that bit).
- frame_start never affects the holding register or dout_valid.
- clr_err and a new overrun in the same cycle: the set wins, so overrun_sticky stays 1.
- States:
  - COLLECT (bit_cnt<WIDTH-1) -> LAST on an accepted bit when bit_cnt==WIDTH-2.
  - LAST -> COLLECT on an accepted bit (word complete).
  - Any state -> COLLECT on frame_start.
  - The state may be implemented as the bit_cnt compare; no extra visible state.
- Reset mid-word or mid-hold: everything returns to reset values immediately. The pending word is lost without an overrun flag.
- Inputs are synchronous to clk; no metastability handling inside.

Decomposition:
- Shared package shift_pkg:
  - SHIFT_WIDTH default constant (8).
  - typedef for the word type, logic [SHIFT_WIDTH-1:0].
  - enum for the COLLECT/LAST state.
- One natural sub-module, shift_out_buf:
  - One-entry valid/ready holding register.
  - Inputs: load, load_data.
  - Outputs: dout, dout_valid, drop pulse.
  - Reused by the transmit-side staging logic.

Test Plan:
- LSB_FIRST=1, dout_ready=1; send bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> dout=8'hA5, dout_valid=1 for one cycle, starting the cycle after the 8th bit.
- LSB_FIRST=1; same 8 bits with random sin_valid gaps of 0..3 cycles -> dout=8'hA5; bit_cnt steps 0..7 only on valid cycles.
- Hold dout_ready=0; send 0x3C then 0xFF -> dout stays 8'h3C; overrun pulses exactly once on the 16th bit +1 cycle; overrun_sticky=1. Pulse clr_err -> sticky=0. Raise dout_ready -> 0x3C accepted, dout_valid=0.
- Send 3 bits, then frame_start with sin_valid=1 and sin_data=1, then 7 more bits 0 -> dout=8'h01 and bit_cnt=1 after the frame_start cycle. Repeat with sin_valid=0 on frame_start -> bit_cnt=0.
- Drop rst_n asynchronously (between clock edges) after 5 bits and while a word is held -> all outputs 0 immediately. After release, 8 bits of 0x5A -> dout=8'h5A.
- LSB_FIRST=0; send bits 1,0,1,0,0,1,0,1 with dout_ready toggling -> dout=8'hA5; transfer only on a cycle with dout_ready=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the serial word assembler and its output holding register.
// Also used by the transmit-side staging logic.
package shift_pkg;

  localparam int SHIFT_WIDTH = 8;

  typedef logic [SHIFT_WIDTH-1:0] shift_word_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_LAST    = 1'b1
  } shift_state_e;

endpackage

// File: rtl/shift_out_buf.sv
// One-entry valid/ready holding register. A load into an occupied slot that is
// not being drained this cycle is dropped and flagged on the combinational drop pulse.
module shift_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             drop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Slot is free when empty or being consumed in this same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (load) begin
      if (!valid_q || dout_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out word assembler: collects WIDTH qualified bits into a
// word and hands it to a one-entry valid/ready holding register.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sin_valid,
  input  logic                       sin_data,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       overrun_sticky,
  input  logic                       clr_err
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted_s, fresh_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, sticky_q, sticky_d;
  logic             load_s, drop_s;
  shift_state_e     state_s;

  // LAST is simply "the next accepted bit completes the word".
  assign state_s   = (cnt_q == LAST_CNT) ? ST_LAST : ST_COLLECT;
  assign shifted_s = LSB_FIRST ? {sin_data, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], sin_data};
  assign fresh_s   = LSB_FIRST ? {sin_data, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sin_data};

  // Next shift register / bit count; frame_start realigns before anything else.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    if (frame_start) begin
      if (sin_valid) begin
        shreg_d = fresh_s;
        cnt_d   = CW'(1);
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (sin_valid) begin
      shreg_d = shifted_s;
      case (state_s)
        ST_LAST: begin
          cnt_d  = '0;
          load_s = 1'b1;
        end
        ST_COLLECT: cnt_d = cnt_q + CW'(1);
        default:    cnt_d = '0;
      endcase
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  // A new overrun outranks a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (drop_s) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Assembler and error flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      overrun_q <= drop_s;
      sticky_q  <= sticky_d;
    end
  end

  shift_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .load_data  (shreg_d),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .drop       (drop_s)
  );

  assign bit_cnt        = cnt_q;
  assign overrun        = overrun_q;
  assign overrun_sticky = sticky_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench: one LSB-first and one MSB-first deserializer fed the same stream.
module tb_shift_deserializer;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sin_valid = 1'b0, sin_data = 1'b0, frame_start = 1'b0;
  logic       dout_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] dout, dout_m;
  logic       dout_valid, dout_valid_m;
  logic [3:0] bit_cnt, bit_cnt_m;
  logic       overrun, overrun_m, overrun_sticky, overrun_sticky_m;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [7:0]  word;
    logic [15:0] gaps;     // 2-bit idle-cycle count after each bit, bit 0 in [1:0]
    logic [7:0]  exp_lsb;
    logic [7:0]  exp_msb;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .bit_cnt(bit_cnt), .overrun(overrun),
    .overrun_sticky(overrun_sticky), .clr_err(clr_err)
  );

  shift_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .frame_start(frame_start), .dout(dout_m), .dout_valid(dout_valid_m),
    .dout_ready(dout_ready), .bit_cnt(bit_cnt_m), .overrun(overrun_m),
    .overrun_sticky(overrun_sticky_m), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic d);
    sin_valid = 1'b1;
    sin_data  = d;
    step();
    sin_valid = 1'b0;
    sin_data  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 16'h0000, 8'hA5, 8'hA5};
    vecs[1] = '{8'hA5, 16'h1B6E, 8'hA5, 8'hA5};
    vecs[2] = '{8'h12, 16'h0000, 8'h12, 8'h48};
    vecs[3] = '{8'hC8, 16'h0401, 8'hC8, 8'h13};
    vecs[4] = '{8'hF0, 16'h5555, 8'hF0, 8'h0F};
    vecs[5] = '{8'h01, 16'h0000, 8'h01, 8'h80};

    @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_cnt", bit_cnt, 4'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_sticky", overrun_sticky, 1'b0);
    rst_n = 1'b1;
    step();

    // Table: each word with its gap pattern, downstream always ready.
    dout_ready = 1'b1;
    foreach (vecs[v]) begin
      for (int i = 0; i < 8; i++) begin
        send_bit(vecs[v].word[i]);
        if (i < 7) begin
          check("tbl_cnt", bit_cnt, 32'(i + 1));
          check("tbl_early_valid", dout_valid, 1'b0);
          for (int g = 0; g < int'(vecs[v].gaps[2*i +: 2]); g++) begin
            step();
            check("tbl_gap_cnt", bit_cnt, 32'(i + 1));
          end
        end
      end
      check("tbl_valid", dout_valid, 1'b1);
      check("tbl_dout_lsb", dout, vecs[v].exp_lsb);
      check("tbl_dout_msb", dout_m, vecs[v].exp_msb);
      check("tbl_cnt_wrap", bit_cnt, 4'd0);
      step();
      check("tbl_valid_drop", dout_valid, 1'b0);
    end

    // Back-to-back words at full rate: no loss.
    for (int i = 0; i < 16; i++) begin
      send_bit(i < 8 ? vecs[0].word[i] : vecs[2].word[i-8]);
      check("b2b_no_overrun", overrun, 1'b0);
      if (i == 7) check("b2b_first", dout, 8'hA5);
      if (i == 8) check("b2b_drained", dout_valid, 1'b0);
    end
    check("b2b_second", dout, 8'h12);
    check("b2b_second_valid", dout_valid, 1'b1);
    step();

    // Overrun while held, then clear and drain.
    dout_ready = 1'b0;
    send_word(8'h3C);
    check("ovr_held", dout, 8'h3C);
    check("ovr_held_valid", dout_valid, 1'b1);
    send_word(8'hFF);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_sticky", overrun_sticky, 1'b1);
    check("ovr_dout_kept", dout, 8'h3C);
    step();
    check("ovr_pulse_end", overrun, 1'b0);
    check("ovr_sticky_hold", overrun_sticky, 1'b1);
    check("ovr_stable", dout, 8'h3C);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_sticky", overrun_sticky, 1'b0);
    dout_ready = 1'b1;
    step();
    check("ovr_drain", dout_valid, 1'b0);

    // clr_err coinciding with a new drop: set wins.
    dout_ready = 1'b0;
    send_word(8'h11);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    clr_err = 1'b1;
    send_bit(1'b1);
    clr_err = 1'b0;
    check("clrset_pulse", overrun, 1'b1);
    check("clrset_sticky", overrun_sticky, 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clrset_cleared", overrun_sticky, 1'b0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_keeps_valid", dout_valid, 1'b1);
    check("fs_keeps_dout", dout, 8'h11);
    dout_ready = 1'b1;
    step();
    check("fs_drain", dout_valid, 1'b0);

    // frame_start with a valid bit realigns to that bit.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("fs_pre_cnt", bit_cnt, 4'd3);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    check("fs_cnt_one", bit_cnt, 4'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("fs_valid", dout_valid, 1'b1);
    check("fs_dout_lsb", dout, 8'h01);
    check("fs_dout_msb", dout_m, 8'h80);
    step();
    // frame_start without a bit clears the partial word.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs0_cnt", bit_cnt, 4'd0);
    send_word(8'hC8);
    check("fs0_dout_lsb", dout, 8'hC8);
    check("fs0_dout_msb", dout_m, 8'h13);
    step();

    // Asynchronous reset mid-word with a held word and sticky set.
    dout_ready = 1'b0;
    send_word(8'h77);
    send_word(8'h66);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("ar_pre_cnt", bit_cnt, 4'd5);
    check("ar_pre_sticky", overrun_sticky, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_dout", dout, 8'h00);
    check("ar_valid", dout_valid, 1'b0);
    check("ar_cnt", bit_cnt, 4'd0);
    check("ar_sticky", overrun_sticky, 1'b0);
    check("ar_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    step();
    send_word(8'h5A);
    check("ar_post_valid", dout_valid, 1'b1);
    check("ar_post_dout", dout, 8'h5A);
    step();

    // MSB-first instance with dout_ready toggling.
    for (int i = 0; i < 8; i++) begin
      dout_ready = (i % 2) == 1;
      send_bit(vecs[0].word[i]);
    end
    dout_ready = 1'b0;
    check("msb_valid", dout_valid_m, 1'b1);
    check("msb_dout", dout_m, 8'hA5);
    step();
    check("msb_hold_valid", dout_valid_m, 1'b1);
    check("msb_hold_dout", dout_m, 8'hA5);
    dout_ready = 1'b1;
    step();
    check("msb_drain", dout_valid_m, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
